leaf_inject_arbiter: RTL and testbench
======================================

Name: leaf_inject_arbiter

Overview:
- Shares one BFT leaf injection port among num_req local requesters.
- Round-robin grant; packs {valid, dest, payload} into a p_sz packet and drives the subtree leaf_k_in.
- Retries on the leaf's resend signal with fixed backoff; drops the packet after max_retry resends.
- One instance per leaf that hosts multiple streams; sits between the PE-side stream logic and the subtree leaf ports.

Parameters:
- num_req, 4, number of requesters (2..8)
- payload_sz, 43, payload bits per packet
- p_sz, 49, packet width; addr_w = p_sz-payload_sz-1 (5, derived localparam)
- max_retry, 7, resends tolerated per packet before drop (1..255)
- backoff, 2, idle cycles between a resend and re-presentation (0..255)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  num_req  requester i has a packet
- req_ready  out  num_req  one-hot accept strobe; transfer when valid&ready
- req_dest  in  num_req*addr_w  destination leaf, slice i
- req_payload  in  num_req*payload_sz  payload, slice i
- leaf_out  out  p_sz  packet to subtree leaf_k_in; bit p_sz-1 = valid, [p_sz-2:payload_sz] = dest, [payload_sz-1:0] = payload
- resend_i  in  1  subtree resend_k; high = packet currently on leaf_out rejected
- busy  out  1  holding a packet (SEND or HOLDOFF)
- drop_o  out  1  one-cycle pulse on packet drop
- err_o  out  1  sticky drop flag
- clear_err  in  1  synchronous clear of err_o
- stat_sent  out  16  see Optional Feature
- stat_retry  out  16  see Optional Feature

Behaviour:
- Reset (reset=0): state IDLE, leaf_out=0, req_ready=0, busy=0, drop_o=0, err_o=0, rr pointer=0, counters=0. Takes effect immediately; a held packet is discarded.
- States: IDLE, SEND, HOLDOFF.
- Grant: round-robin over req_valid, starting at index rr_ptr+1 (mod num_req) after the last grant; rr_ptr=0 out of reset, so the first search starts at 1. Grant is offered in IDLE, or in SEND when resend_i=0. req_ready[g] is combinational, at most one bit high. The packet is captured on that edge and the next state is SEND.
- Requesters hold dest/payload stable while valid until ready.
- SEND: leaf_out = {1'b1, dest, payload} from the holding register. resend_i is sampled on the same edge.
  - resend_i=0: packet delivered. Next grant if any valid, else IDLE.
  - resend_i=1 and retry_cnt<max_retry: retry_cnt++. Go to HOLDOFF with timer=backoff; if backoff=0, stay in SEND and re-drive the same packet.
  - resend_i=1 and retry_cnt==max_retry: drop packet, drop_o=1 for one cycle, err_o=1, go to IDLE. No grant is offered in that cycle.
- HOLDOFF: leaf_out=0; timer decrements each cycle; go to SEND on the edge where timer==1.
- retry_cnt clears on every new grant. A packet is presented at most max_retry+1 times.
- leaf_out=0 in IDLE and HOLDOFF; never an X or stale valid bit.
- busy=1 in SEND and HOLDOFF.
- Latency: valid at cycle t in IDLE → ready at t → leaf_out valid at t+1. Back-to-back delivery gives 1 packet/cycle.
- clear_err and a drop on the same edge: err_o=1 (set wins).
- resend_i is ignored outside SEND.

Optional Feature:
- Macro: LEAF_INJECT_ARB_STATS_EN.
- Defined: stat_sent counts delivered packets; stat_retry counts resends. Both are 16-bit, saturate at 16'hFFFF, and are cleared by reset or clear_err (increment wins on the same edge).
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Single request: req_valid=4'b0001, dest=5'd3, payload=43'h1234, resend_i=0 → ready[0] at t, leaf_out={1,5'd3,43'h1234} at t+1, IDLE at t+2 with leaf_out=0.
- Fairness: req_valid=4'b1111 held, resend_i=0 → grants 1,2,3,0,1,… one per cycle; no requester waits more than 4 grants.
- Retry with backoff=2: resend_i=1 for the first presentation only → leaf_out 0 for 2 cycles, same packet re-presented, delivered; stat_retry=1, stat_sent=1 (STATS_EN).
- Drop with max_retry=7: resend_i stuck at 1 → 8 presentations, then drop_o pulses once, err_o=1, IDLE. clear_err → err_o=0; a drop coinciding with clear_err leaves err_o=1.
- Reset mid-HOLDOFF: assert reset asynchronously → leaf_out=0 and busy=0 before the next edge; after release a pending request is granted starting from index 1.
- backoff=0: single resend → the packet stays on leaf_out with no gap cycle and is delivered on the next cycle.

Source files
------------

// File: rtl/leaf_inject_arbiter.sv
// leaf_inject_arbiter
// Shares one BFT leaf injection port among num_req local requesters.
// Round-robin grant, packs {valid, dest, payload} onto leaf_out, re-presents a
// packet after a fixed backoff whenever the subtree signals resend, and drops
// it once max_retry resends have been absorbed.
// Optional build macro: LEAF_INJECT_ARB_STATS_EN adds saturating delivered and
// resend counters on stat_sent / stat_retry (tied to 0 when undefined).
//
// state   | meaning
// IDLE    | nothing held, leaf_out=0, grant offered
// SEND    | held packet on leaf_out, resend_i sampled on the edge
// HOLDOFF | packet held after a resend, leaf_out=0 until the backoff expires

module leaf_inject_arbiter #(
  parameter int num_req    = 4,
  parameter int payload_sz = 43,
  parameter int p_sz       = 49,
  parameter int max_retry  = 7,
  parameter int backoff    = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [num_req-1:0]                          req_valid,
  output logic [num_req-1:0]                          req_ready,
  input  logic [num_req*(p_sz-payload_sz-1)-1:0]      req_dest,
  input  logic [num_req*payload_sz-1:0]               req_payload,
  output logic [p_sz-1:0]                             leaf_out,
  input  logic                                        resend_i,
  output logic                                        busy,
  output logic                                        drop_o,
  output logic                                        err_o,
  input  logic                                        clear_err,
  output logic [15:0]                                 stat_sent,
  output logic [15:0]                                 stat_retry
);

  localparam int addr_w = p_sz - payload_sz - 1;
  localparam int RR_W   = (num_req > 1) ? $clog2(num_req) : 1;

  localparam logic [7:0] RETRY_LIM = 8'(max_retry);
  localparam logic [7:0] BACKOFF_V = 8'(backoff);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [RR_W-1:0]         rr_ptr;
  logic [RR_W-1:0]         grant_idx;
  logic [RR_W-1:0]         idx_v;
  logic                    grant_vld;
  logic                    grant_open;
  logic                    accept;
  logic                    retry_ev;
  logic                    drop_ev;
  int                      idx;

  logic [7:0]              retry_cnt;
  logic [7:0]              timer;
  logic [addr_w-1:0]       hold_dest;
  logic [payload_sz-1:0]   hold_payload;

  // Round-robin search: first valid requester at rr_ptr+1, rr_ptr+2, ... (mod num_req)
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 1; k <= num_req; k++) begin
      idx   = (int'(rr_ptr) + k) % num_req;
      idx_v = idx[RR_W-1:0];
      if (!grant_vld && req_valid[idx_v]) begin
        grant_vld = 1'b1;
        grant_idx = idx_v;
      end
    end
  end

  // Next-state decode; grant is only open in IDLE or on a clean delivery in SEND
  always_comb begin
    state_nxt  = state;
    grant_open = 1'b0;
    retry_ev   = 1'b0;
    drop_ev    = 1'b0;
    case (state)
      IDLE: begin
        grant_open = 1'b1;
        if (grant_vld) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (!resend_i) begin
          grant_open = 1'b1;
          state_nxt  = grant_vld ? SEND : IDLE;
        end else if (retry_cnt < RETRY_LIM) begin
          retry_ev  = 1'b1;
          state_nxt = (backoff == 0) ? SEND : HOLDOFF;
        end else begin
          drop_ev   = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLDOFF: begin
        if (timer <= 8'd1) begin
          state_nxt = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gating with reset keeps ready low while the block is held in reset
  assign accept    = reset & grant_open & grant_vld;
  assign req_ready = accept ? (num_req'(1) << grant_idx) : '0;

  assign leaf_out  = (state == SEND) ? {1'b1, hold_dest, hold_payload} : '0;
  assign busy      = (state == SEND) || (state == HOLDOFF);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Packet capture, round-robin pointer, retry count and backoff timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      hold_dest    <= '0;
      hold_payload <= '0;
      retry_cnt    <= '0;
      timer        <= '0;
    end else begin
      if (accept) begin
        rr_ptr       <= grant_idx;
        hold_dest    <= req_dest[grant_idx*addr_w +: addr_w];
        hold_payload <= req_payload[grant_idx*payload_sz +: payload_sz];
        retry_cnt    <= '0;
      end else if (retry_ev) begin
        retry_cnt    <= retry_cnt + 8'd1;
      end

      if (retry_ev) begin
        timer <= BACKOFF_V;
      end else if (state == HOLDOFF && timer != 8'd0) begin
        timer <= timer - 8'd1;
      end
    end
  end

  // Drop pulse and sticky error; a drop on the same edge as clear_err keeps err_o set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      drop_o <= drop_ev;
      if (drop_ev) begin
        err_o <= 1'b1;
      end else if (clear_err) begin
        err_o <= 1'b0;
      end
    end
  end

`ifdef LEAF_INJECT_ARB_STATS_EN
  logic        sent_ev;
  logic        resend_ev;
  logic [15:0] sent_q;
  logic [15:0] retry_q;

  assign sent_ev   = (state == SEND) & ~resend_i;
  assign resend_ev = (state == SEND) &  resend_i;

  // Saturating counters; an increment beats clear_err on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_q  <= '0;
      retry_q <= '0;
    end else begin
      if (sent_ev) begin
        if (sent_q != 16'hFFFF) begin
          sent_q <= sent_q + 16'd1;
        end
      end else if (clear_err) begin
        sent_q <= '0;
      end

      if (resend_ev) begin
        if (retry_q != 16'hFFFF) begin
          retry_q <= retry_q + 16'd1;
        end
      end else if (clear_err) begin
        retry_q <= '0;
      end
    end
  end

  assign stat_sent  = sent_q;
  assign stat_retry = retry_q;
`else
  assign stat_sent  = 16'd0;
  assign stat_retry = 16'd0;
`endif

endmodule

// File: tb/tb_leaf_inject_arbiter.sv
// Directed bench for leaf_inject_arbiter. dut_a uses default parameters
// (backoff=2, max_retry=7); dut_b shares the requester inputs but has backoff=0
// and its own resend line.

module tb_leaf_inject_arbiter;

  localparam int NR = 4;
  localparam int PS = 43;
  localparam int P  = 49;
  localparam int AW = 5;

`ifdef LEAF_INJECT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_dest;
  logic [NR*PS-1:0] req_payload;
  logic             clear_err;
  logic             resend_a, resend_b;
  logic [NR-1:0]    ready_a, ready_b;
  logic [P-1:0]     leaf_a, leaf_b;
  logic             busy_a, busy_b, drop_a, drop_b, err_a, err_b;
  logic [15:0]      sent_a, retry_a, sent_b, retry_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  leaf_inject_arbiter #(.num_req(NR), .payload_sz(PS), .p_sz(P), .max_retry(7), .backoff(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_a),
    .req_dest(req_dest), .req_payload(req_payload), .leaf_out(leaf_a),
    .resend_i(resend_a), .busy(busy_a), .drop_o(drop_a), .err_o(err_a),
    .clear_err(clear_err), .stat_sent(sent_a), .stat_retry(retry_a)
  );

  leaf_inject_arbiter #(.num_req(NR), .payload_sz(PS), .p_sz(P), .max_retry(7), .backoff(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_b),
    .req_dest(req_dest), .req_payload(req_payload), .leaf_out(leaf_b),
    .resend_i(resend_b), .busy(busy_b), .drop_o(drop_b), .err_o(err_b),
    .clear_err(clear_err), .stat_sent(sent_b), .stat_retry(retry_b)
  );

  function automatic logic [P-1:0] pkt(input logic [AW-1:0] d, input logic [PS-1:0] p);
    return {1'b1, d, p};
  endfunction

  function automatic logic [AW-1:0] d_of(input int i);
    return AW'(i + 8);
  endfunction

  function automatic logic [PS-1:0] p_of(input int i);
    return PS'(43'h100 + i);
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] d, input logic [PS-1:0] p);
    req_dest[i*AW +: AW]    = d;
    req_payload[i*PS +: PS] = p;
  endtask

  // drive window: just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // sample point: well before the next rising edge
  task automatic mid();
    #3;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    resend_a  = 1'b0;
    resend_b  = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    req_valid   = 4'b1111;
    req_dest    = '0;
    req_payload = '0;
    resend_a    = 1'b0;
    resend_b    = 1'b0;
    clear_err   = 1'b0;
    #2;
    n_chk++; if (leaf_a !== '0) $display("FAIL reset_leaf: got %h want 0", leaf_a); else n_pass++;
    n_chk++; if (ready_a !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", ready_a); else n_pass++;
    n_chk++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
    n_chk++; if (drop_a !== 1'b0) $display("FAIL reset_drop: got %b want 0", drop_a); else n_pass++;
    n_chk++; if (err_a !== 1'b0) $display("FAIL reset_err: got %b want 0", err_a); else n_pass++;
    n_chk++; if (sent_a !== 16'd0 || retry_a !== 16'd0) $display("FAIL reset_stats: got %h/%h want 0/0", sent_a, retry_a); else n_pass++;
    req_valid = '0;
    @(posedge clk);
    #4;
    reset = 1'b1;
  endtask

  task automatic test_single();
    cyc();
    set_req(0, 5'd3, 43'h1234);
    req_valid = 4'b0001;
    mid();
    n_chk++; if (ready_a !== 4'b0001) $display("FAIL single_ready: got %b want 0001", ready_a); else n_pass++;
    n_chk++; if (leaf_a !== '0) $display("FAIL single_idle_leaf: got %h want 0", leaf_a); else n_pass++;
    cyc();
    req_valid = '0;
    mid();
    n_chk++; if (leaf_a !== pkt(5'd3, 43'h1234)) $display("FAIL single_leaf: got %h want %h", leaf_a, pkt(5'd3, 43'h1234)); else n_pass++;
    n_chk++; if (busy_a !== 1'b1) $display("FAIL single_busy: got %b want 1", busy_a); else n_pass++;
    n_chk++; if (ready_a !== 4'b0000) $display("FAIL single_ready_off: got %b want 0000", ready_a); else n_pass++;
    cyc();
    mid();
    n_chk++; if (leaf_a !== '0) $display("FAIL single_after_leaf: got %h want 0", leaf_a); else n_pass++;
    n_chk++; if (busy_a !== 1'b0) $display("FAIL single_after_busy: got %b want 0", busy_a); else n_pass++;
  endtask

  task automatic test_fairness();
    int exp_g [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic [NR-1:0] w;
    cyc();
    for (int i = 0; i < NR; i++) set_req(i, d_of(i), p_of(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      mid();
      w = 4'b0001 << exp_g[k];
      n_chk++; if (ready_a !== w) $display("FAIL fair_grant%0d: got %b want %b", k, ready_a, w); else n_pass++;
      if (k > 0) begin
        n_chk++;
        if (leaf_a !== pkt(d_of(exp_g[k-1]), p_of(exp_g[k-1])))
          $display("FAIL fair_leaf%0d: got %h want %h", k, leaf_a, pkt(d_of(exp_g[k-1]), p_of(exp_g[k-1])));
        else n_pass++;
      end
      cyc();
    end
    req_valid = '0;
    mid();
    n_chk++; if (leaf_a !== pkt(d_of(0), p_of(0))) $display("FAIL fair_last_leaf: got %h want %h", leaf_a, pkt(d_of(0), p_of(0))); else n_pass++;
    n_chk++; if (ready_a !== 4'b0000) $display("FAIL fair_last_ready: got %b want 0000", ready_a); else n_pass++;
    cyc();
    mid();
    n_chk++; if (leaf_a !== '0) $display("FAIL fair_idle_leaf: got %h want 0", leaf_a); else n_pass++;
  endtask

  task automatic test_retry_backoff();
    logic [P-1:0] p2;
    p2 = pkt(5'd17, 43'h5_5555_AAAA);
    do_reset();
    cyc();
    set_req(2, 5'd17, 43'h5_5555_AAAA);
    req_valid = 4'b0100;
    mid();
    n_chk++; if (ready_a !== 4'b0100) $display("FAIL retry_ready: got %b want 0100", ready_a); else n_pass++;
    cyc();
    req_valid = '0;
    resend_a  = 1'b1;
    mid();
    n_chk++; if (leaf_a !== p2) $display("FAIL retry_first: got %h want %h", leaf_a, p2); else n_pass++;
    cyc();
    resend_a = 1'b0;
    mid();
    n_chk++; if (leaf_a !== '0 || busy_a !== 1'b1) $display("FAIL retry_gap1: got leaf %h busy %b want 0/1", leaf_a, busy_a); else n_pass++;
    cyc();
    mid();
    n_chk++; if (leaf_a !== '0 || busy_a !== 1'b1) $display("FAIL retry_gap2: got leaf %h busy %b want 0/1", leaf_a, busy_a); else n_pass++;
    cyc();
    mid();
    n_chk++; if (leaf_a !== p2) $display("FAIL retry_again: got %h want %h", leaf_a, p2); else n_pass++;
    cyc();
    mid();
    n_chk++; if (leaf_a !== '0 || busy_a !== 1'b0) $display("FAIL retry_done: got leaf %h busy %b want 0/0", leaf_a, busy_a); else n_pass++;
    n_chk++; if (drop_a !== 1'b0 || err_a !== 1'b0) $display("FAIL retry_noerr: got drop %b err %b want 0/0", drop_a, err_a); else n_pass++;
    n_chk++; if (sent_a !== (STATS ? 16'd1 : 16'd0)) $display("FAIL retry_stat_sent: got %0d want %0d", sent_a, STATS ? 1 : 0); else n_pass++;
    n_chk++; if (retry_a !== (STATS ? 16'd1 : 16'd0)) $display("FAIL retry_stat_retry: got %0d want %0d", retry_a, STATS ? 1 : 0); else n_pass++;
  endtask

  task automatic test_drop();
    logic [P-1:0] p3, p0;
    int pres, bad, seen_ready, pres2;
    bit found;
    p3 = pkt(5'd30, 43'h7_0000_0003);
    p0 = pkt(5'd1, 43'h0_0ABC_DEF0);
    pres = 0; bad = 0; seen_ready = 0; found = 0;
    cyc();
    set_req(3, 5'd30, 43'h7_0000_0003);
    set_req(0, 5'd1, 43'h0_0ABC_DEF0);
    req_valid = 4'b1000;
    resend_a  = 1'b1;
    mid();
    n_chk++; if (ready_a !== 4'b1000) $display("FAIL drop_grant: got %b want 1000", ready_a); else n_pass++;
    for (int n = 0; n < 60 && !found; n++) begin
      cyc();
      if (n == 0) req_valid = 4'b0001;
      mid();
      if (drop_a) found = 1'b1;
      else begin
        if (leaf_a[P-1]) begin
          pres++;
          if (leaf_a !== p3) bad++;
        end
        if (ready_a !== 4'b0000) seen_ready++;
      end
    end
    n_chk++; if (found !== 1'b1) $display("FAIL drop_seen: got %b want 1", found); else n_pass++;
    n_chk++; if (pres !== 8) $display("FAIL drop_presentations: got %0d want 8", pres); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL drop_content: got %0d wrong packets want 0", bad); else n_pass++;
    n_chk++; if (seen_ready !== 0) $display("FAIL drop_no_grant: got %0d ready cycles want 0", seen_ready); else n_pass++;
    n_chk++; if (err_a !== 1'b1 || busy_a !== 1'b0 || leaf_a !== '0) $display("FAIL drop_state: got err %b busy %b leaf %h want 1/0/0", err_a, busy_a, leaf_a); else n_pass++;
    n_chk++; if (ready_a !== 4'b0001) $display("FAIL drop_next_grant: got %b want 0001", ready_a); else n_pass++;
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    req_valid = '0;
    mid();
    n_chk++; if (err_a !== 1'b0 || drop_a !== 1'b0) $display("FAIL drop_clear: got err %b drop %b want 0/0", err_a, drop_a); else n_pass++;
    n_chk++; if (leaf_a !== p0) $display("FAIL drop_p0_first: got %h want %h", leaf_a, p0); else n_pass++;
    pres2 = 1;
    for (int n = 0; n < 60 && pres2 < 8; n++) begin
      cyc();
      mid();
      if (leaf_a[P-1]) pres2++;
    end
    n_chk++; if (pres2 !== 8) $display("FAIL drop_p0_presentations: got %0d want 8", pres2); else n_pass++;
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    resend_a  = 1'b0;
    mid();
    n_chk++; if (drop_a !== 1'b1 || err_a !== 1'b1) $display("FAIL drop_set_wins: got drop %b err %b want 1/1", drop_a, err_a); else n_pass++;
    cyc();
    mid();
    n_chk++; if (drop_a !== 1'b0 || err_a !== 1'b1) $display("FAIL drop_pulse_sticky: got drop %b err %b want 0/1", drop_a, err_a); else n_pass++;
    cyc();
    clear_err = 1'b1;
    mid();
    cyc();
    clear_err = 1'b0;
    mid();
    n_chk++; if (err_a !== 1'b0) $display("FAIL drop_final_clear: got %b want 0", err_a); else n_pass++;
  endtask

  task automatic test_reset_holdoff();
    logic [P-1:0] p1;
    p1 = pkt(5'd9, 43'h1_2345_6789);
    cyc();
    set_req(1, 5'd9, 43'h1_2345_6789);
    set_req(3, 5'd30, 43'h7_0000_0003);
    req_valid = 4'b0010;
    mid();
    n_chk++; if (ready_a !== 4'b0010) $display("FAIL rsth_grant: got %b want 0010", ready_a); else n_pass++;
    cyc();
    req_valid = '0;
    resend_a  = 1'b1;
    mid();
    n_chk++; if (leaf_a !== p1) $display("FAIL rsth_send: got %h want %h", leaf_a, p1); else n_pass++;
    cyc();
    resend_a = 1'b0;
    mid();
    n_chk++; if (busy_a !== 1'b1 || leaf_a !== '0) $display("FAIL rsth_holdoff: got busy %b leaf %h want 1/0", busy_a, leaf_a); else n_pass++;
    #1;
    reset     = 1'b0;
    req_valid = 4'b1001;
    #1;
    n_chk++; if (busy_a !== 1'b0 || leaf_a !== '0) $display("FAIL rsth_async: got busy %b leaf %h want 0/0", busy_a, leaf_a); else n_pass++;
    n_chk++; if (ready_a !== 4'b0000) $display("FAIL rsth_ready_in_reset: got %b want 0000", ready_a); else n_pass++;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_chk++; if (ready_a !== 4'b1000) $display("FAIL rsth_rr_restart: got %b want 1000", ready_a); else n_pass++;
    cyc();
    req_valid = '0;
    mid();
    n_chk++; if (leaf_a !== pkt(5'd30, 43'h7_0000_0003)) $display("FAIL rsth_deliver: got %h want %h", leaf_a, pkt(5'd30, 43'h7_0000_0003)); else n_pass++;
    cyc();
    mid();
    n_chk++; if (leaf_a !== '0 || busy_a !== 1'b0) $display("FAIL rsth_idle: got leaf %h busy %b want 0/0", leaf_a, busy_a); else n_pass++;
  endtask

  task automatic test_backoff_zero();
    logic [P-1:0] pb;
    pb = pkt(5'd22, 43'h3_00FF_00FF);
    do_reset();
    cyc();
    set_req(0, 5'd22, 43'h3_00FF_00FF);
    req_valid = 4'b0001;
    mid();
    n_chk++; if (ready_b !== 4'b0001) $display("FAIL bo0_grant: got %b want 0001", ready_b); else n_pass++;
    cyc();
    req_valid = '0;
    resend_b  = 1'b1;
    mid();
    n_chk++; if (leaf_b !== pb) $display("FAIL bo0_first: got %h want %h", leaf_b, pb); else n_pass++;
    cyc();
    resend_b = 1'b0;
    mid();
    n_chk++; if (leaf_b !== pb || busy_b !== 1'b1) $display("FAIL bo0_no_gap: got leaf %h busy %b want %h/1", leaf_b, busy_b, pb); else n_pass++;
    cyc();
    mid();
    n_chk++; if (leaf_b !== '0 || busy_b !== 1'b0) $display("FAIL bo0_done: got leaf %h busy %b want 0/0", leaf_b, busy_b); else n_pass++;
    n_chk++; if (drop_b !== 1'b0 || err_b !== 1'b0) $display("FAIL bo0_noerr: got drop %b err %b want 0/0", drop_b, err_b); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_retry_backoff();
    test_drop();
    test_reset_holdoff();
    test_backoff_zero();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
